// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state codes for the FPGA <-> Arduino serial link.
// Both the transmit and receive paths import this package.
package uart_pkg;

    localparam int CLK_FREQ     = 100_000_000;
    localparam int UART_BAUD    = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;

endpackage

// File: rtl/tx_byte_fifo.sv
// Small synchronous FIFO buffering producer bytes ahead of the UART shifter.
// Head entry is visible on o_data combinationally; pushes while full are dropped.
module tx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_to_arduino.sv
// UART 8N1 transmitter toward the Arduino: byte FIFO feeding a start/data/stop shifter.
// STOP pops the next byte on its last cycle so queued frames go out with no idle gap.
module uart_tx_to_arduino #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_byte,
    output logic                          tx_ready,
    output logic                          SerialToArduino,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    uart_state
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_line;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_bit_done;
    logic [7:0]       w_head;
    logic [FCW-1:0]   w_count;

    assign w_bit_done = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_push     = tx_valid && !w_full;

    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (r_state == IDLE)
                w_pop = 1'b1;
            else if (r_state == STOP && w_bit_done)
                w_pop = 1'b1;
        end
    end

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (tx_byte),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The line level for the next bit is registered on the edge that enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_line    <= UART_IDLE_LEVEL;
        end else begin
            case (r_state)
                IDLE: begin
                    r_line    <= UART_IDLE_LEVEL;
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_line  <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_line    <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_line  <= UART_IDLE_LEVEL;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_line    <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_line  <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_clk_cnt <= '0;
                    r_line    <= UART_IDLE_LEVEL;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign SerialToArduino = r_line;
    assign uart_state      = r_state;
    assign fifo_count      = w_count;
    assign tx_ready        = (w_count != FCW'(FIFO_DEPTH));
    assign tx_busy         = (r_state != IDLE) || (w_count != '0);

endmodule

// File: doc/uart_tx_to_arduino.md
Name: uart_tx_to_arduino

Overview:
UART 8N1 transmitter that sends bytes from FPGA logic to the Arduino over a single serial line. It is the companion to the existing FPGA-side UART receive path. Both use the same bit timing: 100 MHz clock, 115200 baud, CLKS_PER_BIT = 868. A small byte FIFO in front of the shifter lets producers push short bursts without waiting on line timing. A debug state output is provided for LED display.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (CLK_FREQ / UART_BAUD); legal range ≥ 2.
FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥ 2.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  synchronous, active-high reset.
tx_valid  input  1  producer has a byte on tx_byte this cycle.
tx_byte  input  8  byte to transmit.
tx_ready  output  1  FIFO can accept a byte; push occurs when tx_valid && tx_ready.
SerialToArduino  output  1  serial line, registered; idle high.
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
uart_state  output  3  FSM state code, for LEDs.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered or derived from registers.
- Reset values:
  - SerialToArduino = 1; tx_ready = 1; tx_busy = 0; fifo_count = 0; uart_state = IDLE (0).
  - FIFO pointers cleared; bit counter and clock counter = 0.
- Frame format: start bit (0), data bits 0..7 (LSB first), one stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. A frame lasts 10*CLKS_PER_BIT cycles.
- FSM states and codes: IDLE=0, START=1, DATA=2, STOP=3. Codes 4–7 are unused; if reached, the FSM goes to IDLE.
  - IDLE: line = 1. If the FIFO is non-empty, pop the head into the shift register, clear the clock counter, and go to START.
  - START: line = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
  - DATA: line = shift[bit index] for CLKS_PER_BIT cycles. Bit index increments after each bit. After bit 7 completes, go to STOP.
  - STOP: line = 1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a push at cycle N into an empty FIFO with the FSM in IDLE gives fifo_count = 1 at N+1. The pop happens at N+1, and SerialToArduino = 0 from cycle N+2.
- FIFO rules:
  - tx_ready = (fifo_count != FIFO_DEPTH), computed from the registered count only.
  - A push while full is ignored: no state change and no overwrite.
  - A push and a pop in the same cycle leave fifo_count unchanged, and the data order is preserved.
  - A pop while empty never occurs by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- tx_busy = (state != IDLE) || (fifo_count != 0).
- A change on tx_byte while tx_valid is low has no effect. A byte is captured only on the accept cycle.
- Reset mid-frame: on the next edge the line returns to 1, FIFO contents are discarded, and the FSM enters IDLE. The truncated frame is not resent.
- Counter widths: clock counter is clog2(CLKS_PER_BIT) bits; bit index is 3 bits.

Decomposition:
- Shared package (uart_pkg):
  - Constants: CLK_FREQ, UART_BAUD, CLKS_PER_BIT.
  - State codes: IDLE, START, DATA, STOP.
  - UART_IDLE_LEVEL = 1.
  - The receive path uses the same package.
- Sub-module: tx_byte_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterized by depth and width 8.
- The FSM and shifter stay in uart_tx_to_arduino.

Test Plan:
1. Run with CLKS_PER_BIT=8. After reset, push 0xA5 once. Line is low from cycle N+2 for 8 cycles. Data bits are 1,0,1,0,0,1,0,1 at 8 cycles each. Stop bit is high for 8 cycles. tx_busy then falls and uart_state returns to 0.
2. Burst-push 0x01, 0x02, 0x03, 0x04 on consecutive cycles. fifo_count peaks at 3, then decrements as frames start. Four frames are sent back-to-back with no idle gap between stop and start. Decoded bytes match in order.
3. Push 6 bytes while FIFO_DEPTH=4 and the first frame is in progress. tx_ready drops once 4 bytes are held. Pushes with tx_ready=0 are dropped. The receiving model decodes exactly the accepted bytes.
4. Push on the same cycle the STOP state pops the last entry. fifo_count is unchanged that cycle. The next frame carries the pushed byte with no gap.
5. Assert rst during DATA bit 3 of 0xFF with 2 bytes queued. Line is 1 on the next cycle. fifo_count = 0 and uart_state = 0. No further frames are sent.
6. Run with CLKS_PER_BIT=868 and send 0x55. Each bit lasts exactly 868 cycles. A loopback into the existing receiver yields rx_byte = 0x55 with the ready pulse asserted.
